// File: rtl/fft16_pkg.sv
// Shared constants, FSM state type and operand-address helpers for the
// 16-point radix-2 DIT butterfly scheduler.
package fft16_pkg;
    localparam int N      = 16;
    localparam int NBFLY  = 8;
    localparam int NSTAGE = 4;
    localparam int AW     = 4;
    localparam int TWW    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    // a = grp*2*span + pos, with grp = k>>s and pos = k & (span-1)
    function automatic logic [AW-1:0] bfly_addr_a(input logic [1:0] s, input logic [2:0] k);
        logic [AW-1:0] kk;
        logic [AW-1:0] mask;
        kk   = {1'b0, k};
        mask = (AW'(1) << s) - AW'(1);
        return ((kk >> s) << (s + 1)) | (kk & mask);
    endfunction

    function automatic logic [TWW-1:0] bfly_tw(input logic [1:0] s, input logic [2:0] k);
        logic [AW-1:0] kk;
        logic [AW-1:0] mask;
        logic [AW-1:0] t;
        kk   = {1'b0, k};
        mask = (AW'(1) << s) - AW'(1);
        t    = (kk & mask) << (2'd3 - s);
        return t[TWW-1:0];
    endfunction
endpackage

// File: rtl/fft16_wb_delay.sv
// Write-back alignment: delays the issued {valid, addr_a, addr_b} by DEPTH
// cycles so results land exactly when the butterfly output is registered.
module fft16_wb_delay
    import fft16_pkg::*;
#(
    parameter int DEPTH = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [AW-1:0] in_a,
    input  logic [AW-1:0] in_b,
    output logic          out_vld,
    output logic [AW-1:0] out_a,
    output logic [AW-1:0] out_b
);
    logic [DEPTH:1]         vld_pipe;
    logic [DEPTH:1][AW-1:0] a_pipe;
    logic [DEPTH:1][AW-1:0] b_pipe;

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_pipe <= '0;
            a_pipe   <= '0;
            b_pipe   <= '0;
        end else begin
            vld_pipe[1] <= in_vld;
            a_pipe[1]   <= in_a;
            b_pipe[1]   <= in_b;
            for (int i = 2; i <= DEPTH; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                a_pipe[i]   <= a_pipe[i-1];
                b_pipe[i]   <= b_pipe[i-1];
            end
        end
    end

    // Outputs are forced quiet while reset is held, not just after the edge.
    assign out_vld = rst && vld_pipe[DEPTH];
    assign out_a   = out_vld ? a_pipe[DEPTH] : '0;
    assign out_b   = out_vld ? b_pipe[DEPTH] : '0;
endmodule

// File: rtl/fft16_sched.sv
// 16-point in-place radix-2 DIT scheduler: issues 8 butterflies per stage,
// drains the read+butterfly latency between stages, then pulses done.
module fft16_sched
    import fft16_pkg::*;
#(
    parameter int BFLY_LAT = 4,
    parameter int RD_LAT   = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [1:0]     stage,
    output logic           rd_en,
    output logic [AW-1:0]  rd_addr_a,
    output logic [AW-1:0]  rd_addr_b,
    output logic [TWW-1:0] tw_idx,
    output logic           wr_en,
    output logic [AW-1:0]  wr_addr_a,
    output logic [AW-1:0]  wr_addr_b
);
    localparam int L  = RD_LAT + BFLY_LAT;
    localparam int CW = $clog2(L + 1);

    state_t        state, state_nxt;
    logic [1:0]    stage_q, stage_nxt;
    logic [2:0]    k_q, k_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          issue;
    logic [AW-1:0] addr_a;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            stage_q <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            stage_q <= stage_nxt;
            k_q     <= k_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stage_nxt = stage_q;
        k_nxt     = k_q;
        cnt_nxt   = cnt_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    stage_nxt = '0;
                    k_nxt     = '0;
                end
            end
            ISSUE: begin
                k_nxt = k_q + 3'd1;
                if (k_q == 3'(NBFLY - 1)) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end
            end
            DRAIN: begin
                // Waiting the full L cycles keeps the next stage's first read
                // behind the previous stage's last write-back.
                cnt_nxt = cnt_q + CW'(1);
                if (cnt_q == CW'(L - 1)) begin
                    cnt_nxt = '0;
                    if (stage_q == 2'(NSTAGE - 1)) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = ISSUE;
                        stage_nxt = stage_q + 2'd1;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
                stage_nxt = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign issue     = rst && (state == ISSUE);
    assign addr_a    = bfly_addr_a(stage_q, k_q);
    assign rd_en     = issue;
    assign rd_addr_a = issue ? addr_a : '0;
    assign rd_addr_b = issue ? (addr_a | (AW'(1) << stage_q)) : '0;
    assign tw_idx    = issue ? bfly_tw(stage_q, k_q) : '0;

    assign busy  = rst && (state != IDLE);
    assign done  = rst && (state == FIN);
    assign stage = rst ? stage_q : 2'd0;

    fft16_wb_delay #(.DEPTH(L)) u_wb_delay (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (rd_en),
        .in_a    (rd_addr_a),
        .in_b    (rd_addr_b),
        .out_vld (wr_en),
        .out_a   (wr_addr_a),
        .out_b   (wr_addr_b)
    );
endmodule

// File: tb/tb_fft16_sched.sv
// Scoreboard bench for fft16_sched: default-latency and long-latency instances,
// expected read/write/done events queued at stimulus time and popped by a monitor.
module tb_fft16_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    always #5 clk = ~clk;

    logic       busy0, done0, rd0, wr0, busy1, done1, rd1, wr1;
    logic [1:0] st0, st1;
    logic [3:0] ra0, rb0, wa0, wb0, ra1, rb1, wa1, wb1;
    logic [2:0] tw0, tw1;

    fft16_sched u0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .stage(st0),
        .rd_en(rd0), .rd_addr_a(ra0), .rd_addr_b(rb0), .tw_idx(tw0),
        .wr_en(wr0), .wr_addr_a(wa0), .wr_addr_b(wb0)
    );

    fft16_sched #(.BFLY_LAT(6), .RD_LAT(2)) u1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .stage(st1),
        .rd_en(rd1), .rd_addr_a(ra1), .rd_addr_b(rb1), .tw_idx(tw1),
        .wr_en(wr1), .wr_addr_a(wa1), .wr_addr_b(wb1)
    );

    typedef struct {
        int d;
        int cyc;
        int a;
        int b;
        int tw;
    } ev_t;

    ev_t rdq[$];
    ev_t wrq[$];
    ev_t dnq[$];
    ev_t obs_rd[$];
    ev_t obs_wr[$];

    int checks = 0;
    int errors = 0;
    int pc = 0;

    always @(posedge clk) pc <= pc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, pc);
        end
    endtask

    // Expected events of one run started at edge t0; events after lim are dropped.
    task automatic push_run(input int d, input int t0, input int lat, input int lim);
        ev_t e;
        for (int s = 0; s < 4; s++) begin
            for (int g = 0; g < (8 >> s); g++) begin
                for (int p = 0; p < (1 << s); p++) begin
                    e.d   = d;
                    e.cyc = t0 + 1 + s * (8 + lat) + g * (1 << s) + p;
                    e.a   = g * 2 * (1 << s) + p;
                    e.b   = e.a + (1 << s);
                    e.tw  = p * (8 >> s);
                    if (e.cyc <= lim) rdq.push_back(e);
                    e.cyc = e.cyc + lat;
                    e.tw  = 0;
                    if (e.cyc <= lim) wrq.push_back(e);
                end
            end
        end
        e.d = d; e.cyc = t0 + 4 * (8 + lat) + 1; e.a = 0; e.b = 0; e.tw = 0;
        if (e.cyc <= lim) dnq.push_back(e);
    endtask

    always @(negedge clk) begin
        logic r, w, dn;
        int a, b, tw, wa, wb;
        ev_t e;
        for (int d = 0; d < 2; d++) begin
            r  = (d == 0) ? rd0 : rd1;
            w  = (d == 0) ? wr0 : wr1;
            dn = (d == 0) ? done0 : done1;
            a  = (d == 0) ? int'(ra0) : int'(ra1);
            b  = (d == 0) ? int'(rb0) : int'(rb1);
            tw = (d == 0) ? int'(tw0) : int'(tw1);
            wa = (d == 0) ? int'(wa0) : int'(wa1);
            wb = (d == 0) ? int'(wb0) : int'(wb1);
            if (r) begin
                if (rdq.size() == 0) chk("unexpected rd_en", 1, 0);
                else begin
                    e = rdq.pop_front();
                    chk("rd dut", d, e.d);
                    chk("rd cycle", pc, e.cyc);
                    chk("rd_addr_a", a, e.a);
                    chk("rd_addr_b", b, e.b);
                    chk("tw_idx", tw, e.tw);
                    if (d == 0) begin
                        e.a = a; e.b = b; e.tw = tw;
                        obs_rd.push_back(e);
                    end
                end
            end else begin
                chk("rd addr idle zero", a | b | tw, 0);
            end
            if (w) begin
                if (wrq.size() == 0) chk("unexpected wr_en", 1, 0);
                else begin
                    e = wrq.pop_front();
                    chk("wr dut", d, e.d);
                    chk("wr cycle", pc, e.cyc);
                    chk("wr_addr_a", wa, e.a);
                    chk("wr_addr_b", wb, e.b);
                    if (d == 0) begin
                        e.a = wa; e.b = wb;
                        obs_wr.push_back(e);
                    end
                end
            end else begin
                chk("wr addr idle zero", wa | wb, 0);
            end
            if (dn) begin
                if (dnq.size() == 0) chk("unexpected done", 1, 0);
                else begin
                    e = dnq.pop_front();
                    chk("done dut", d, e.d);
                    chk("done cycle", pc, e.cyc);
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (pc < c) @(negedge clk);
    endtask

    task automatic pulse(input int d, input int c);
        wait_until(c);
        #1;
        if (d == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, mrd, mwr, twor;
        repeat (3) @(negedge clk);
        chk("reset busy", busy0, 0);
        chk("reset done", done0, 0);
        chk("reset rd_en", rd0, 0);
        chk("reset wr_en", wr0, 0);
        chk("reset stage", st0, 0);
        chk("reset addrs", ra0 | rb0 | wa0 | wb0 | tw0, 0);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle busy", busy0, 0);

        // Run 1 with ignored re-pulses, then a fresh run at +55.
        t0 = pc;
        push_run(0, t0, 5, 1 << 30);
        pulse(0, t0);
        wait_until(t0 + 1);
        chk("busy after start", busy0, 1);
        pulse(0, t0 + 5);
        wait_until(t0 + 9);
        chk("stage held in drain", st0, 0);
        wait_until(t0 + 14);
        chk("stage 1 on reissue", st0, 1);
        pulse(0, t0 + 30);
        pulse(0, t0 + 53);
        wait_until(t0 + 54);
        chk("busy after done", busy0, 0);
        push_run(0, t0 + 55, 5, 1 << 30);
        pulse(0, t0 + 55);
        wait_until(t0 + 55 + 56);

        chk("run1 rd count", obs_rd.size(), 64);
        if (obs_rd.size() >= 32 && obs_wr.size() >= 32) begin
            chk("s1k3 a", obs_rd[11].a, 5);
            chk("s1k3 b", obs_rd[11].b, 7);
            chk("s1k3 tw", obs_rd[11].tw, 4);
            chk("s2k5 a", obs_rd[21].a, 9);
            chk("s2k5 b", obs_rd[21].b, 13);
            chk("s2k5 tw", obs_rd[21].tw, 2);
            chk("s3k7 a", obs_rd[31].a, 7);
            chk("s3k7 b", obs_rd[31].b, 15);
            chk("s3k7 tw", obs_rd[31].tw, 7);
            twor = 0;
            for (int k = 0; k < 8; k++) twor |= obs_rd[k].tw;
            chk("stage0 tw zero", twor, 0);
            for (int s = 0; s < 4; s++) begin
                mrd = 0; mwr = 0;
                for (int k = 0; k < 8; k++) begin
                    mrd |= (1 << obs_rd[s*8+k].a) | (1 << obs_rd[s*8+k].b);
                    mwr |= (1 << obs_wr[s*8+k].a) | (1 << obs_wr[s*8+k].b);
                end
                chk("stage rd coverage", mrd, 32'hffff);
                chk("stage wr coverage", mwr, 32'hffff);
            end
        end else begin
            chk("run1 observed pairs", obs_rd.size(), 64);
        end

        // Abort by reset at cycle 20 of a run.
        t1 = pc + 2;
        push_run(0, t1, 5, t1 + 20);
        pulse(0, t1);
        wait_until(t1 + 20);
        #1 rst = 1'b0;
        wait_until(t1 + 21);
        chk("abort busy", busy0, 0);
        chk("abort rd_en", rd0, 0);
        chk("abort wr_en", wr0, 0);
        #1 rst = 1'b1;
        wait_until(t1 + 90);
        chk("abort stays idle", busy0, 0);

        // Long-latency instance: L = 8.
        t2 = pc + 2;
        push_run(1, t2, 8, 1 << 30);
        pulse(1, t2);
        wait_until(t2 + 9);
        chk("L8 drain busy", busy1, 1);
        wait_until(t2 + 66);
        chk("L8 busy after done", busy1, 0);
        repeat (3) @(negedge clk);

        chk("rd queue drained", rdq.size(), 0);
        chk("wr queue drained", wrq.size(), 0);
        chk("done queue drained", dnq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
